// File: rtl/alu_pkg.sv
// Shared opcode, state and data types for the pipelined ALU and its iterative mul/div unit.
// Opcodes 16..31 are unassigned and reported as illegal by alu_pipe.
package alu_pkg;

    localparam int OP_W   = 5;
    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] UbitData;

    typedef enum logic [OP_W-1:0] {
        ADD   = 5'd0,
        SUB   = 5'd1,
        AND   = 5'd2,
        OR    = 5'd3,
        XOR   = 5'd4,
        SLT   = 5'd5,
        SLTU  = 5'd6,
        SLL   = 5'd7,
        SRL   = 5'd8,
        SRA   = 5'd9,
        MUL   = 5'd10,
        MULHU = 5'd11,
        DIV   = 5'd12,
        DIVU  = 5'd13,
        REM   = 5'd14,
        REMU  = 5'd15
    } Op;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;

    function automatic logic is_iterative(input Op op);
        return (op == MUL) || (op == MULHU) || (op == DIV) ||
               (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shift-add multiplier and restoring divider sharing one adder; one bit per cycle.
// Latency: done rises WIDTH cycles after start; no backpressure, result holds until next start.
// Backpressure: none; the caller simply leaves the result parked while done is high.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  Op                op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    Op                op_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dvsr;
    logic             is_mul_q;
    logic             neg_q;
    logic             neg_r;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;

    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign signed_op = (op == DIV) || (op == REM);
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Multiply: hi + multiplicand. Divide: {rem, next dividend bit} - divisor, carry-out = no borrow.
    always_comb begin
        if (is_mul_q) begin
            add_x   = {1'b0, hi};
            add_y   = {1'b0, dvsr};
            add_cin = 1'b0;
        end else begin
            add_x   = {hi, lo[WIDTH-1]};
            add_y   = ~{1'b0, dvsr};
            add_cin = 1'b1;
        end
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= ADD;
            hi       <= '0;
            lo       <= '0;
            dvsr     <= '0;
            is_mul_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            op_q     <= op;
            is_mul_q <= (op == MUL) || (op == MULHU);
            hi       <= '0;
            if ((op == MUL) || (op == MULHU)) begin
                lo   <= b;
                dvsr <= a;
            end else begin
                lo   <= a_mag;
                dvsr <= b_mag;
            end
            // Divide by zero keeps the all-ones quotient unsigned; remainder sign follows a.
            neg_q    <= (a_neg ^ b_neg) && (b != '0);
            neg_r    <= a_neg;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (is_mul_q) begin
                if (lo[0]) begin
                    {hi, lo} <= {add_sum[WIDTH:0], lo[WIDTH-1:1]};
                end else begin
                    {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
                end
            end else if (add_sum[WIDTH+1]) begin
                hi <= add_sum[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi <= {hi[WIDTH-2:0], lo[WIDTH-1]};
                lo <= {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done  = (cnt == '0);
    assign q_fix = neg_q ? -lo : lo;
    assign r_fix = neg_r ? -hi : hi;

    always_comb begin
        case (op_q)
            MUL:       result = lo;
            MULHU:     result = hi;
            DIV, DIVU: result = q_fix;
            default:   result = r_fix;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU, one op per cycle; ALU_PIPE_MULDIV_EN adds the iterative MUL/DIV unit.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for iterative ops.
// Backpressure: in_ready low while iterating or while an undrained result blocks the output register.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_op,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [ID_WIDTH-1:0] in_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_x,
    output logic [ID_WIDTH-1:0] out_id,
    output logic                out_illegal,
    output logic                busy
);
    localparam int SHW = $clog2(WIDTH);

    state_e              state;
    state_e              state_nxt;
    Op                   op;
    logic                accept;
    logic                out_free;
    logic                load_sc;
    logic                load_it;
    logic                iter_start;
    logic                iter_done;
    logic [WIDTH-1:0]    iter_x;
    logic [WIDTH-1:0]    sc_x;
    logic                sc_ill;
    logic [SHW-1:0]      shamt;
    logic [ID_WIDTH-1:0] id_q;

    assign op       = Op'(in_op);
    assign shamt    = in_b[SHW-1:0];
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ITER);

`ifdef ALU_PIPE_MULDIV_EN
    assign iter_start = accept && is_iterative(op);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .op     (op),
        .a      (in_a),
        .b      (in_b),
        .done   (iter_done),
        .result (iter_x)
    );
`else
    assign iter_start = 1'b0;
    assign iter_done  = 1'b0;
    assign iter_x     = '0;
`endif

    // Mul/div opcodes fall to the illegal default; with the iterative unit present they never load from here.
    always_comb begin
        sc_x   = '0;
        sc_ill = 1'b0;
        case (op)
            ADD:     sc_x = in_a + in_b;
            SUB:     sc_x = in_a - in_b;
            AND:     sc_x = in_a & in_b;
            OR:      sc_x = in_a | in_b;
            XOR:     sc_x = in_a ^ in_b;
            SLT:     sc_x = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            SLTU:    sc_x = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            SLL:     sc_x = in_a << shamt;
            SRL:     sc_x = in_a >> shamt;
            SRA:     sc_x = $unsigned($signed(in_a) >>> shamt);
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_sc   = 1'b0;
        load_it   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (iter_start) begin
                        state_nxt = ITER;
                    end else begin
                        load_sc = 1'b1;
                    end
                end
            end
            ITER: begin
                if (iter_done && out_free) begin
                    load_it   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q <= '0;
        end else if (accept) begin
            id_q <= in_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_id      <= '0;
            out_illegal <= 1'b0;
        end else if (load_sc) begin
            out_valid   <= 1'b1;
            out_x       <= sc_x;
            out_id      <= in_id;
            out_illegal <= sc_ill;
        end else if (load_it) begin
            out_valid   <= 1'b1;
            out_x       <= iter_x;
            out_id      <= id_q;
            out_illegal <= 1'b0;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
